// File: rtl/keypad4x4_scan.sv
// ============================================================================
// Module   : keypad4x4_scan
// Purpose  : 4x4 matrix keypad scanner with debounce and a hex-digit shift value
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad4x4_scan #(
    parameter int SCAN_DIV       = 15,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DB_W           = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  i_col,
    input  logic        i_clear,
    output logic [3:0]  o_row,
    output logic        o_key_valid,
    output logic [3:0]  o_key_code,
    output logic        o_key_down,
    output logic [31:0] o_value
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [3:0]          col_meta;
    logic [3:0]          col_sync;
    logic [SCAN_DIV-1:0] div;
    logic [1:0]          row;
    logic [15:0]         scan_map;
    logic [15:0]         full_map;
    logic                slot_end;
    logic                scan_done;
    logic [4:0]          bit_count;
    logic [3:0]          hit_idx;
    logic                is_none;
    logic                is_single;
    state_t              state;
    logic [3:0]          cand;
    logic [DB_W-1:0]     cnt;
    logic [DB_W-1:0]     cnt_inc;
    logic                cnt_done;
    logic                accept;

    assign slot_end  = &div;
    assign scan_done = slot_end && (row == 2'd3);

    // The current row's columns are merged in so the row-3 slot end sees the whole scan.
    always_comb begin
        full_map = scan_map;
        full_map[{row, 2'b00} +: 4] = ~col_sync;
    end

    always_comb begin
        bit_count = '0;
        hit_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (full_map[i]) begin
                bit_count = bit_count + 5'd1;
                hit_idx   = 4'(i);
            end
        end
    end

    assign is_none   = (bit_count == 5'd0);
    assign is_single = (bit_count == 5'd1);
    assign cnt_inc   = cnt + DB_W'(1);
    assign cnt_done  = (cnt_inc == DB_W'(DEBOUNCE_SCANS));
    assign accept    = scan_done && (state == DEBOUNCE) && is_single
                       && (hit_idx == cand) && cnt_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            div      <= '0;
            row      <= '0;
            o_row    <= 4'b1110;
            scan_map <= '0;
        end else begin
            col_meta <= i_col;
            col_sync <= col_meta;
            div      <= div + SCAN_DIV'(1);
            if (slot_end) begin
                row      <= row + 2'd1;
                o_row    <= ~(4'b0001 << (row + 2'd1));
                scan_map <= (row == 2'd3) ? 16'h0000 : full_map;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cand        <= '0;
            cnt         <= '0;
            o_key_valid <= 1'b0;
            o_key_code  <= '0;
            o_key_down  <= 1'b0;
            o_value     <= '0;
        end else begin
            o_key_valid <= 1'b0;
            if (i_clear) begin
                o_value <= '0;
            end else if (accept) begin
                o_value <= {o_value[27:0], cand};
            end
            if (accept) begin
                o_key_valid <= 1'b1;
                o_key_code  <= cand;
            end
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            state <= DEBOUNCE;
                            cand  <= hit_idx;
                            cnt   <= DB_W'(1);
                        end
                    end
                    DEBOUNCE: begin
                        if (is_single && (hit_idx == cand)) begin
                            cnt <= cnt_inc;
                            if (cnt_done) begin
                                state      <= PRESSED;
                                o_key_down <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (is_none) begin
                            state <= RELEASE;
                            cnt   <= DB_W'(1);
                        end
                    end
                    RELEASE: begin
                        // Any activity, even a multi-key map, counts as the key still held.
                        if (is_none) begin
                            cnt <= cnt_inc;
                            if (cnt_done) begin
                                state      <= IDLE;
                                o_key_down <= 1'b0;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad4x4_scan.sv
// Bench for keypad4x4_scan: keypad modelled as row-dependent column pull-downs,
// accepted events checked against a queue of expected {code, value} records.
`default_nettype none

module tb_keypad4x4_scan;

    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        i_clear = 1'b0;
    logic [3:0]  i_col;
    logic [3:0]  o_row;
    logic        o_key_valid;
    logic [3:0]  o_key_code;
    logic        o_key_down;
    logic [31:0] o_value;
    logic [15:0] keys = 16'h0000;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] value;
    } exp_t;

    typedef struct {
        logic [15:0] keys;
        logic        accept;
        logic [3:0]  code;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] model_value = 32'h0;

    keypad4x4_scan #(
        .SCAN_DIV(2),
        .DEBOUNCE_SCANS(3),
        .DB_W(3)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_col(i_col),
        .i_clear(i_clear),
        .o_row(o_row),
        .o_key_valid(o_key_valid),
        .o_key_code(o_key_code),
        .o_key_down(o_key_down),
        .o_value(o_value)
    );

    always #5 clk = ~clk;

    always_comb begin
        i_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !o_row[r]) i_col[c] = 1'b0;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && o_key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: got code %h expected no event", o_key_code);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check32("event_code", {28'h0, o_key_code}, {28'h0, e.code});
                check32("event_value", o_value, e.value);
            end
        end
    end

    task automatic press_expect(input logic [3:0] code);
        model_value = {model_value[27:0], code};
        sb.push_back('{code, model_value});
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending events expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk) i_clear = 1'b1;
        @(negedge clk) i_clear = 1'b0;
        model_value = 32'h0;
        check32("clear_value", o_value, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_row"},   {28'h0, o_row}, 32'he);
        check32({tag, "_valid"}, {31'h0, o_key_valid}, 32'h0);
        check32({tag, "_code"},  {28'h0, o_key_code}, 32'h0);
        check32({tag, "_down"},  {31'h0, o_key_down}, 32'h0);
        check32({tag, "_value"}, o_value, 32'h0);
    endtask

    task automatic wait_row(input logic [3:0] r, input string tag);
        int n;
        n = 0;
        while (o_row !== r && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_row !== r) begin
            fails++;
            $display("FAIL %s: got row %b expected %b", tag, o_row, r);
        end
    endtask

    initial begin
        // Reset and idle row sequence
        #1 rstn = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        wait_row(4'b0111, "sync_row3");
        wait_row(4'b1110, "sync_row0");
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++) begin
                check32("row_cycle", {28'h0, o_row}, {28'h0, ~(4'b0001 << s)});
                @(negedge clk);
            end
        wait_scans(2);
        check32("idle_value", o_value, 32'h0);

        // Single held key 9
        keys = 16'h0200;
        press_expect(4'h9);
        drain(4 * SCAN + 3);
        wait_scans(5);
        check32("held_code", {28'h0, o_key_code}, 32'h9);
        check32("held_value", o_value, 32'h9);
        check32("held_down", {31'h0, o_key_down}, 32'h1);
        keys = 16'h0000;
        wait_scans(6);
        check32("released_down", {31'h0, o_key_down}, 32'h0);

        // Bounce: one scan on, one scan off
        for (int i = 0; i < 10; i++) begin
            keys = 16'h0002;
            wait_scans(1);
            check32("bounce_down_on", {31'h0, o_key_down}, 32'h0);
            keys = 16'h0000;
            wait_scans(1);
            check32("bounce_down_off", {31'h0, o_key_down}, 32'h0);
        end
        wait_scans(4);

        // Table of press/release sequences
        vecs[0] = '{16'h0048, 1'b0, 4'h0};
        vecs[1] = '{16'h0008, 1'b1, 4'h3};
        vecs[2] = '{16'h0020, 1'b1, 4'h5};
        for (int d = 1; d <= 9; d++) vecs[d+2] = '{16'h0001 << d, 1'b1, 4'(d)};
        do_clear();
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin
                check32("value_35", o_value, 32'h35);
                do_clear();
            end
            keys = vecs[i].keys;
            if (vecs[i].accept) press_expect(vecs[i].code);
            wait_scans(5);
            drain(1);
            keys = 16'h0000;
            wait_scans(5);
        end
        check32("value_wrap", o_value, 32'h23456789);

        // Release shorter than debounce keeps the key down
        keys = 16'h0080;
        press_expect(4'h7);
        wait_scans(5);
        drain(1);
        keys = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            check32("short_release_down", {31'h0, o_key_down}, 32'h1);
        end
        keys = 16'h0080;
        wait_scans(4);
        check32("repress_down", {31'h0, o_key_down}, 32'h1);
        keys = 16'h0000;
        wait_scans(3);
        repeat (24) @(negedge clk);
        check32("long_release_down", {31'h0, o_key_down}, 32'h0);
        wait_scans(2);

        // Clear coinciding with the accept of key A
        wait_row(4'b0111, "align_row3");
        wait_row(4'b1110, "align_row0");
        keys = 16'h0400;
        model_value = 32'h0;
        sb.push_back('{4'hA, 32'h0});
        repeat (47) @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk) i_clear = 1'b0;
        drain(2);
        check32("clear_accept_code", {28'h0, o_key_code}, 32'ha);
        check32("clear_accept_value", o_value, 32'h0);
        keys = 16'h0000;
        wait_scans(5);

        // Reset during debounce, key held across reset
        keys = 16'h1000;
        press_expect(4'hC);
        wait_scans(5);
        drain(1);
        keys = 16'h0000;
        wait_scans(5);
        keys = 16'h0800;
        repeat (30) @(negedge clk);
        rstn = 1'b0;
        #2 check_reset_outputs("mid_reset");
        sb.delete();
        model_value = 32'h0;
        @(negedge clk) rstn = 1'b1;
        press_expect(4'hB);
        drain(6 * SCAN);
        check32("post_reset_down", {31'h0, o_key_down}, 32'h1);
        keys = 16'h0000;
        wait_scans(5);
        check32("final_down", {31'h0, o_key_down}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
